// File: rtl/vga_frame_scheduler_pkg.sv
// Shared constants and register-map types for the VGA frame scheduler.
package vga_frame_scheduler_pkg;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned V_ACTIVE = 480;

    localparam int unsigned HCNT_W = 11;
    localparam int unsigned VCNT_W = 10;
    localparam int unsigned FCNT_W = 8;

    // Control/status registers sit directly above the NREGS shadow registers
    typedef enum logic [1:0] {
        REG_CTRL_OFS   = 2'd0,
        REG_STATUS_OFS = 2'd1,
        REG_FCNT_OFS   = 2'd2
    } reg_ofs_e;

    localparam int unsigned STAT_PENDING_BIT = 0;
    localparam int unsigned STAT_VBLANK_BIT  = 1;
    localparam int unsigned STAT_IRQ_BIT     = 2;

    localparam int unsigned CTRL_ARM_BIT = 0;
    localparam int unsigned CTRL_ACK_BIT = 1;

endpackage

// File: rtl/vga_frame_scheduler_if.sv
// Avalon-MM slave bus bundle (no waitrequest, read latency 1).
interface vga_frame_scheduler_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
);
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/vga_frame_scheduler_timing_gen.sv
// Pixel-enable, h/v counters and commit-edge/vblank decode for the frame scheduler.
module vga_timing_gen #(
    parameter int unsigned H_TOTAL  = vga_frame_scheduler_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL  = vga_frame_scheduler_pkg::V_TOTAL,
    parameter int unsigned V_ACTIVE = vga_frame_scheduler_pkg::V_ACTIVE
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    output logic                                      pix_en,
    output logic [vga_frame_scheduler_pkg::HCNT_W-1:0] hcount,
    output logic [vga_frame_scheduler_pkg::VCNT_W-1:0] vcount,
    output logic                                      vblank,
    output logic                                      ce_c
);
    import vga_frame_scheduler_pkg::*;

    logic              r_pix_en;
    logic [HCNT_W-1:0] r_hcount;
    logic [VCNT_W-1:0] r_vcount;
    logic              r_vblank;
    logic              w_h_last;
    logic              w_v_last;

    assign w_h_last = (r_hcount == HCNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_vcount == VCNT_W'(V_TOTAL - 1));

    // vblank is registered alongside vcount so it always matches the new line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_en <= 1'b0;
            r_hcount <= '0;
            r_vcount <= '0;
            r_vblank <= 1'b0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (w_h_last) begin
                    r_hcount <= '0;
                    if (w_v_last) begin
                        r_vcount <= '0;
                        r_vblank <= 1'b0;
                    end else begin
                        r_vcount <= r_vcount + VCNT_W'(1);
                        r_vblank <= (r_vcount >= VCNT_W'(V_ACTIVE - 1));
                    end
                end else begin
                    r_hcount <= r_hcount + HCNT_W'(1);
                end
            end
        end
    end

    assign ce_c   = r_pix_en & w_h_last & (r_vcount == VCNT_W'(V_ACTIVE - 1));
    assign pix_en = r_pix_en;
    assign hcount = r_hcount;
    assign vcount = r_vcount;
    assign vblank = r_vblank;

endmodule

// File: rtl/vga_frame_scheduler.sv
// Avalon-MM shadow/active register file with tear-free commit at vblank start.
// Optional irq output enabled by defining VGA_FRAME_SCHEDULER_IRQ_EN.
module vga_frame_scheduler #(
    parameter int unsigned NREGS    = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned H_TOTAL  = vga_frame_scheduler_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL  = vga_frame_scheduler_pkg::V_TOTAL,
    parameter int unsigned V_ACTIVE = vga_frame_scheduler_pkg::V_ACTIVE
) (
    input  logic                    clk,
    input  logic                    reset_n,
    vga_frame_scheduler_if.slave    avs,
    output logic [NREGS*DATA_W-1:0] active_regs,
    output logic                    pix_en,
    output logic [10:0]             hcount,
    output logic [9:0]              vcount,
    output logic                    vblank,
    output logic                    frame_tick
`ifdef VGA_FRAME_SCHEDULER_IRQ_EN
    ,
    output logic                    irq
`endif
);
    import vga_frame_scheduler_pkg::*;

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [ADDR_W-1:0] A_NREGS  = ADDR_W'(NREGS);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(NREGS + int'(REG_CTRL_OFS));
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NREGS + int'(REG_STATUS_OFS));
    localparam logic [ADDR_W-1:0] A_FCNT   = ADDR_W'(NREGS + int'(REG_FCNT_OFS));

    logic [NREGS-1:0][DATA_W-1:0] r_shadow;
    logic [NREGS-1:0][DATA_W-1:0] r_active;
    logic                         r_pending;
    logic [FCNT_W-1:0]            r_frame_cnt;
    logic                         r_frame_tick;
    logic [DATA_W-1:0]            r_readdata;

    logic              w_ce;
    logic              w_wr;
    logic              w_rd;
    logic              w_is_shadow;
    logic              w_ctrl_wr;
    logic              w_arm;
    logic              w_irq_bit;
    logic [DATA_W-1:0] w_rdata;

    vga_timing_gen #(
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .V_ACTIVE (V_ACTIVE)
    ) u_timing (
        .clk    (clk),
        .rst_n  (reset_n),
        .pix_en (pix_en),
        .hcount (hcount),
        .vcount (vcount),
        .vblank (vblank),
        .ce_c   (w_ce)
    );

    assign w_wr        = avs.chipselect & avs.write;
    assign w_rd        = avs.chipselect & avs.read;
    assign w_is_shadow = (avs.address < A_NREGS);
    assign w_ctrl_wr   = w_wr & (avs.address == A_CTRL);
    assign w_arm       = w_ctrl_wr & avs.writedata[CTRL_ARM_BIT];

    // Active copies the pre-write shadow on a CE; a same-clk arm survives for next frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
            r_readdata   <= '0;
        end else begin
            r_frame_tick <= w_ce;
            if (w_wr && w_is_shadow) begin
                r_shadow[avs.address[IDX_W-1:0]] <= avs.writedata;
            end
            if (w_ce) begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                if (r_pending) begin
                    r_active <= r_shadow;
                end
            end
            if (w_arm) begin
                r_pending <= 1'b1;
            end else if (w_ce) begin
                r_pending <= 1'b0;
            end
            r_readdata <= w_rd ? w_rdata : '0;
        end
    end

`ifdef VGA_FRAME_SCHEDULER_IRQ_EN
    logic r_irq;
    logic w_ack;

    assign w_ack = w_ctrl_wr & avs.writedata[CTRL_ACK_BIT];

    // A committing CE wins over a same-clk ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else if (w_ce && r_pending) begin
            r_irq <= 1'b1;
        end else if (w_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign irq       = r_irq;
    assign w_irq_bit = r_irq;
`else
    assign w_irq_bit = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        if (w_is_shadow) begin
            w_rdata = r_shadow[avs.address[IDX_W-1:0]];
        end else if (avs.address == A_STATUS) begin
            w_rdata[STAT_PENDING_BIT] = r_pending;
            w_rdata[STAT_VBLANK_BIT]  = vblank;
            w_rdata[STAT_IRQ_BIT]     = w_irq_bit;
        end else if (avs.address == A_FCNT) begin
            w_rdata = DATA_W'(r_frame_cnt);
        end
    end

    assign avs.readdata = r_readdata;
    assign active_regs  = r_active;
    assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler using a reduced raster to keep frames short.
module tb_vga_frame_scheduler;

    localparam int HT    = 10;
    localparam int VT    = 6;
    localparam int VA    = 4;
    localparam int FRAME = 2 * HT * VT;

    localparam logic [2:0] A_CTRL   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;
    localparam logic [2:0] A_FCNT   = 3'd6;

`ifdef VGA_FRAME_SCHEDULER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
    logic irq;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [31:0] active_regs;
    logic        pix_en;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        vblank;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb_q[$];
    logic       m_pending = 1'b0;
    logic       m_irq     = 1'b0;

    vga_frame_scheduler_if #(.ADDR_W(3), .DATA_W(8)) avs ();

    vga_frame_scheduler #(
        .NREGS    (4),
        .DATA_W   (8),
        .ADDR_W   (3),
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .V_ACTIVE (VA)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .avs         (avs),
        .active_regs (active_regs),
        .pix_en      (pix_en),
        .hcount      (hcount),
        .vcount      (vcount),
        .vblank      (vblank),
        .frame_tick  (frame_tick)
`ifdef VGA_FRAME_SCHEDULER_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] st(input logic vb, input logic pend);
        return {5'd0, m_irq & IRQ_EN, vb, pend};
    endfunction

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        avs.chipselect = 1'b1;
        avs.write      = 1'b1;
        avs.address    = a;
        avs.writedata  = d;
        @(negedge clk);
        avs.chipselect = 1'b0;
        avs.write      = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        sb_q.push_back(exp);
        avs.chipselect = 1'b1;
        avs.read       = 1'b1;
        avs.address    = a;
        @(negedge clk);
        avs.chipselect = 1'b0;
        avs.read       = 1'b0;
        check(tag, 64'(avs.readdata), 64'(sb_q.pop_front()));
    endtask

    // Stops at the negedge just before a commit-edge posedge
    task automatic wait_pre_ce(input string tag);
        int n = 0;
        while (!(pix_en && hcount == 11'(HT - 1) && vcount == 10'(VA - 1)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < 300), 64'(1));
    endtask

    task automatic wait_line(input int v, input string tag);
        int n = 0;
        while (!(vcount == 10'(v) && hcount == 11'd0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < 300), 64'(1));
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        m_pending = 1'b0;
        m_irq     = 1'b0;
    endtask

    initial begin
        int t_h[$];
        int t_v[$];
        int t_f[$];
        int vb_hi  = 0;
        int vb_bad = 0;
        int pe_bad = 0;
        logic [10:0] ph;
        logic [9:0]  pv;
        logic        ppe;

        reset_n        = 1'b0;
        avs.chipselect = 1'b0;
        avs.write      = 1'b0;
        avs.read       = 1'b0;
        avs.address    = '0;
        avs.writedata  = '0;

        // Reset state and raw timing over two frames
        repeat (3) @(negedge clk);
        check("rst_pix_en", 64'(pix_en), 64'(0));
        check("rst_hcount", 64'(hcount), 64'(0));
        check("rst_vcount", 64'(vcount), 64'(0));
        check("rst_vblank", 64'(vblank), 64'(0));
        check("rst_tick", 64'(frame_tick), 64'(0));
        check("rst_active", 64'(active_regs), 64'(0));
        check("rst_rdata", 64'(avs.readdata), 64'(0));
        reset_n = 1'b1;
        ph  = hcount;
        pv  = vcount;
        ppe = pix_en;
        for (int t = 1; t <= 250; t++) begin
            @(negedge clk);
            if (t == 1) check("pix_en_first", 64'(pix_en), 64'(1));
            if (ph == 11'(HT - 1) && hcount == 11'd0) t_h.push_back(t);
            if (pv == 10'(VT - 1) && vcount == 10'd0) t_v.push_back(t);
            if (frame_tick) begin
                t_f.push_back(t);
                if (t_f.size() == 1) begin
                    check("tick_hcount", 64'(hcount), 64'(0));
                    check("tick_vcount", 64'(vcount), 64'(VA));
                end
            end
            if (vblank) vb_hi++;
            if (vblank !== (vcount >= 10'(VA))) vb_bad++;
            if (pix_en === ppe) pe_bad++;
            ph  = hcount;
            pv  = vcount;
            ppe = pix_en;
        end
        check("h_period", 64'((t_h.size() >= 2) ? t_h[1] - t_h[0] : -1), 64'(2 * HT));
        check("v_wraps", 64'(t_v.size()), 64'(2));
        check("v_period", 64'((t_v.size() >= 2) ? t_v[1] - t_v[0] : -1), 64'(FRAME));
        check("tick_count", 64'(t_f.size()), 64'(2));
        check("tick_first", 64'((t_f.size() >= 1) ? t_f[0] : -1), 64'(2 * HT * VA));
        check("tick_period", 64'((t_f.size() >= 2) ? t_f[1] - t_f[0] : -1), 64'(FRAME));
        check("vblank_cycles", 64'(vb_hi), 64'(2 * (VT - VA) * 2 * HT));
        check("vblank_decode", 64'(vb_bad), 64'(0));
        check("pix_toggle", 64'(pe_bad), 64'(0));
        rd(A_FCNT, 8'd2, "fcnt_2frames");
        rd(A_STATUS, st(1'b0, 1'b0), "status_idle");

        // Shadow writes without commit leave active untouched
        wait_line(1, "t2_line");
        wr(3'd0, 8'hA5);
        wr(3'd3, 8'h3C);
        wr(3'd7, 8'hFF);
        rd(3'd7, 8'h00, "rd_unmapped");
        rd(A_CTRL, 8'h00, "rd_ctrl");
        wait_pre_ce("t2_ce");
        @(negedge clk);
        check("t2_tick", 64'(frame_tick), 64'(1));
        check("t2_active", 64'(active_regs), 64'(0));
        rd(3'd0, 8'hA5, "rd_reg0");
        rd(3'd3, 8'h3C, "rd_reg3");

        // Armed commit lands at the CE
        wait_line(2, "t3_line");
        wr(3'd1, 8'h55);
        wr(A_CTRL, 8'h01);
        m_pending = 1'b1;
        rd(A_STATUS, st(1'b0, 1'b1), "t3_status_pend");
        wait_pre_ce("t3_ce");
        rd(A_STATUS, st(1'b0, 1'b1), "t3_status_at_ce");
        check("t3_tick", 64'(frame_tick), 64'(1));
        check("t3_active", 64'(active_regs), 64'(32'h3C0055A5));
        m_pending = 1'b0;
        m_irq     = 1'b1;
        rd(A_STATUS, st(1'b1, 1'b0), "t3_status_after");

        // Shadow write on the CE clk: active takes the pre-write value
        wait_line(1, "t4a_line");
        wr(3'd0, 8'h11);
        wr(A_CTRL, 8'h01);
        wait_pre_ce("t4a_ce");
        wr(3'd2, 8'h77);
        check("t4a_tick", 64'(frame_tick), 64'(1));
        check("t4a_active", 64'(active_regs), 64'(32'h3C005511));
        rd(A_STATUS, st(1'b1, 1'b0), "t4a_status");

        // Commit write on the CE clk stays pending for the next frame
        wait_pre_ce("t4b_ce");
        wr(A_CTRL, 8'h01);
        check("t4b_tick", 64'(frame_tick), 64'(1));
        check("t4b_active", 64'(active_regs), 64'(32'h3C005511));
        m_pending = 1'b1;
        rd(A_STATUS, st(1'b1, 1'b1), "t4b_status");
        wait_pre_ce("t4c_ce");
        @(negedge clk);
        check("t4c_active", 64'(active_regs), 64'(32'h3C775511));
        m_pending = 1'b0;
        rd(A_STATUS, st(1'b1, 1'b0), "t4c_status");
        rd(3'd2, 8'h77, "rd_reg2");

        // Mid-frame reset with a commit pending
        wait_line(1, "t5_line1");
        wr(3'd0, 8'h99);
        wr(A_CTRL, 8'h01);
        wait_line(2, "t5_line2");
        reset_n = 1'b0;
        #1;
        check("t5_hcount", 64'(hcount), 64'(0));
        check("t5_vcount", 64'(vcount), 64'(0));
        check("t5_pix_en", 64'(pix_en), 64'(0));
        check("t5_vblank", 64'(vblank), 64'(0));
        check("t5_tick", 64'(frame_tick), 64'(0));
        check("t5_active", 64'(active_regs), 64'(0));
        check("t5_rdata", 64'(avs.readdata), 64'(0));
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        m_pending = 1'b0;
        m_irq     = 1'b0;
        @(negedge clk);
        check("t5_pix_first", 64'(pix_en), 64'(1));
        check("t5_h_start", 64'(hcount), 64'(0));
        rd(A_STATUS, st(1'b0, 1'b0), "t5_status");
        rd(3'd0, 8'h00, "t5_shadow0");
        wait_pre_ce("t5_ce");
        @(negedge clk);
        check("t5_ce_tick", 64'(frame_tick), 64'(1));
        check("t5_no_commit", 64'(active_regs), 64'(0));
        rd(A_FCNT, 8'd1, "t5_fcnt");

`ifdef VGA_FRAME_SCHEDULER_IRQ_EN
        // irq set by a committing CE, cleared by ack, set wins over same-clk ack
        wr(3'd1, 8'h42);
        wr(A_CTRL, 8'h01);
        wait_pre_ce("t6_ce1");
        @(negedge clk);
        check("t6_irq_set", 64'(irq), 64'(1));
        check("t6_active", 64'(active_regs), 64'(32'h00004200));
        m_irq = 1'b1;
        rd(A_STATUS, st(1'b1, 1'b0), "t6_status");
        wr(A_CTRL, 8'h02);
        m_irq = 1'b0;
        check("t6_irq_ack", 64'(irq), 64'(0));
        wr(A_CTRL, 8'h01);
        wait_pre_ce("t6_ce2");
        wr(A_CTRL, 8'h02);
        m_irq = 1'b1;
        check("t6_set_wins", 64'(irq), 64'(1));
        wr(A_CTRL, 8'h02);
        m_irq = 1'b0;
        check("t6_irq_ack2", 64'(irq), 64'(0));
`endif

        // frame_cnt wraps 255 -> 0
        pulse_reset();
        for (int i = 0; i < 255; i++) begin
            wait_pre_ce("wrap_ce");
            @(negedge clk);
        end
        rd(A_FCNT, 8'hFF, "fcnt_255");
        wait_pre_ce("wrap_last_ce");
        @(negedge clk);
        check("wrap_tick", 64'(frame_tick), 64'(1));
        rd(A_FCNT, 8'h00, "fcnt_wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
